alu_stage: RTL

Execute stage directly downstream of the register file. Accepts an operation plus destination index, receives both operands on the register file's registered read ports one cycle later, computes the result (single-cycle or iterative), then issues a one-cycle write-back (`wb_en`/`wb_idx`/`wb_data`) that drives the register file's `en_write`/`idx_write`/`data_in`. Holds the Z/N/C/V flags register.

---
 rtl/alu_stage_if.sv | 34 +++
 rtl/alu_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_stage_if.sv
// Request/write-back bundle between issue logic, alu_stage and the register file.
interface alu_stage_if #(
    parameter int WORD_SIZE = 16,
    parameter int COUNT     = 32
);
    localparam int COUNT_BITS = $clog2(COUNT);
    localparam int SH_BITS    = $clog2(WORD_SIZE);

    logic                  start;
    logic [3:0]            op;
    logic [COUNT_BITS-1:0] dst;
    logic [SH_BITS-1:0]    shamt;
    logic [WORD_SIZE-1:0]  opnd_a;
    logic [WORD_SIZE-1:0]  opnd_b;
    logic                  busy;
    logic                  wb_en;
    logic [COUNT_BITS-1:0] wb_idx;
    logic [WORD_SIZE-1:0]  wb_data;
    logic                  flag_z;
    logic                  flag_n;
    logic                  flag_c;
    logic                  flag_v;
    logic                  err;

    modport master (
        output start, op, dst, shamt, opnd_a, opnd_b,
        input  busy, wb_en, wb_idx, wb_data, flag_z, flag_n, flag_c, flag_v, err
    );

    modport slave (
        input  start, op, dst, shamt, opnd_a, opnd_b,
        output busy, wb_en, wb_idx, wb_data, flag_z, flag_n, flag_c, flag_v, err
    );
endinterface

// File: rtl/alu_stage.sv
// Execute stage: IDLE -> FETCH -> EXEC* -> WB, one-cycle register-file write-back, Z/N/C/V flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 10.
module alu_stage #(
    parameter int WORD_SIZE = 16,
    parameter int COUNT     = 32
) (
    input  logic        clk,
    input  logic        rst,
    alu_stage_if.slave  bus
);
    localparam int COUNT_BITS = $clog2(COUNT);
    localparam int SH_BITS    = $clog2(WORD_SIZE);
    localparam int W          = WORD_SIZE;
    localparam int CB         = SH_BITS + 1;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                           OP_OR  = 4'd4,  OP_XOR = 4'd5, OP_CMP = 4'd6, OP_MOV = 4'd7,
                           OP_SHL = 4'd8,  OP_SHR = 4'd9, OP_MUL = 4'd10;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

    state_t                state;
    logic [3:0]            op_q;
    logic [COUNT_BITS-1:0] dst_q;
    logic [SH_BITS-1:0]    shamt_q;
    logic [CB-1:0]         cnt;
    logic [W-1:0]          sh_q;
    logic                  busy_q, wb_en_q, err_q;
    logic [COUNT_BITS-1:0] wb_idx_q;
    logic [W-1:0]          wb_data_q;
    logic                  fz, fn, fc, fv;

    logic [W-1:0] a, b;
    assign a = bus.opnd_a;
    assign b = bus.opnd_b;

    // Single-cycle result path, evaluated during FETCH against the live read ports.
    logic [W:0]   sum;
    logic [W-1:0] res;
    logic         res_c, res_v, wr, legal, multi;

    always_comb begin
        sum   = '0;
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        wr    = 1'b1;
        legal = 1'b1;
        multi = 1'b0;
        case (op_q)
            OP_ADD, OP_ADC: begin
                sum   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (op_q == OP_ADC) & fc};
                res   = sum[W-1:0];
                res_c = sum[W];
                res_v = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            OP_SUB, OP_CMP: begin
                sum   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                res   = sum[W-1:0];
                res_c = sum[W];
                res_v = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
                wr    = (op_q != OP_CMP);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_MOV: res = b;
            OP_SHL, OP_SHR: begin
                res   = a;
                multi = (shamt_q != '0);
            end
            OP_MUL: begin
`ifdef ALU_MUL_EN
                multi = 1'b1;
`else
                legal = 1'b0;
                wr    = 1'b0;
`endif
            end
            default: begin
                legal = 1'b0;
                wr    = 1'b0;
            end
        endcase
    end

    logic [W-1:0] sh_nxt;
    logic         sh_out;
    assign sh_nxt = (op_q == OP_SHL) ? {sh_q[W-2:0], 1'b0} : {1'b0, sh_q[W-1:1]};
    assign sh_out = (op_q == OP_SHL) ? sh_q[W-1] : sh_q[0];

    logic [W-1:0] fin_data;
    logic         fin_c;
`ifdef ALU_MUL_EN
    // Product register: high half accumulates, low half starts as B and shifts out the multiplier bits.
    logic [W-1:0]   mca_q;
    logic [2*W-1:0] prod_q, prod_nxt;
    logic [W:0]     psum;
    assign psum     = {1'b0, prod_q[2*W-1:W]} + {1'b0, prod_q[0] ? mca_q : {W{1'b0}}};
    assign prod_nxt = {psum, prod_q[W-1:1]};
    assign fin_data = (op_q == OP_MUL) ? prod_nxt[W-1:0] : sh_nxt;
    assign fin_c    = (op_q == OP_MUL) ? (|prod_nxt[2*W-1:W]) : sh_out;
`else
    assign fin_data = sh_nxt;
    assign fin_c    = sh_out;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            dst_q     <= '0;
            shamt_q   <= '0;
            cnt       <= '0;
            sh_q      <= '0;
            busy_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            err_q     <= 1'b0;
            wb_idx_q  <= '0;
            wb_data_q <= '0;
            fz        <= 1'b0;
            fn        <= 1'b0;
            fc        <= 1'b0;
            fv        <= 1'b0;
`ifdef ALU_MUL_EN
            mca_q     <= '0;
            prod_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    op_q    <= bus.op;
                    dst_q   <= bus.dst;
                    shamt_q <= bus.shamt;
                    busy_q  <= 1'b1;
                    state   <= FETCH;
                end
                FETCH: begin
                    if (!legal) begin
                        err_q <= 1'b1;
                        state <= WB;
                    end else if (multi) begin
                        state <= EXEC;
                        sh_q  <= a;
                        cnt   <= CB'(shamt_q);
`ifdef ALU_MUL_EN
                        if (op_q == OP_MUL) begin
                            cnt    <= CB'(W);
                            mca_q  <= a;
                            prod_q <= {{W{1'b0}}, b};
                        end
`endif
                    end else begin
                        state   <= WB;
                        wb_en_q <= wr;
                        if (wr) begin
                            wb_idx_q  <= dst_q;
                            wb_data_q <= res;
                        end
                        fz <= (res == '0);
                        fn <= res[W-1];
                        fc <= res_c;
                        fv <= res_v;
                    end
                end
                EXEC: begin
                    cnt  <= cnt - 1'b1;
                    sh_q <= sh_nxt;
`ifdef ALU_MUL_EN
                    prod_q <= prod_nxt;
`endif
                    if (cnt == CB'(1)) begin
                        state     <= WB;
                        wb_en_q   <= 1'b1;
                        wb_idx_q  <= dst_q;
                        wb_data_q <= fin_data;
                        fz        <= (fin_data == '0);
                        fn        <= fin_data[W-1];
                        fc        <= fin_c;
                        fv        <= 1'b0;
                    end
                end
                WB: begin
                    wb_en_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.wb_en   = wb_en_q;
    assign bus.err     = err_q;
    assign bus.wb_idx  = wb_idx_q;
    assign bus.wb_data = wb_data_q;
    assign bus.flag_z  = fz;
    assign bus.flag_n  = fn;
    assign bus.flag_c  = fc;
    assign bus.flag_v  = fv;
endmodule
